aer_receiver: RTL and testbench



---
 rtl/aer_pkg.sv | 18 +
 rtl/aer_frame_fifo.sv | 46 ++++
 rtl/aer_receiver.sv | 108 ++++++++++
 tb/tb_aer_receiver.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/aer_pkg.sv
// Shared AER link definitions: address-width and end-marker helpers plus the
// receiver FSM state type.
package aer_pkg;

    function automatic int aer_addr_w(input int n);
        return $clog2(n) + 1;
    endfunction

    function automatic logic [31:0] aer_end_marker(input int w);
        return (w >= 32) ? 32'hFFFF_FFFF : ((32'h1 << w) - 32'h1);
    endfunction

    typedef enum logic {
        IDLE = 1'b0,
        RECV = 1'b1
    } rx_state_t;

endpackage

// File: rtl/aer_frame_fifo.sv
// Show-ahead circular frame buffer; a push into a full FIFO is accepted only
// when a pop happens in the same cycle.
module aer_frame_fifo #(
    parameter int WIDTH = 5,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             do_push;
    logic             do_pop;

    // Extra pointer MSB tells full (wrapped) apart from empty (equal).
    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign dout    = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= din;
    end

endmodule

// File: rtl/aer_receiver.sv
// AER link receiver: rebuilds address bursts into spike frames and queues them.
// Optional AER_RX_STATS_EN adds saturating frame_count/drop_count outputs.
module aer_receiver
    import aer_pkg::*;
#(
    parameter int NO_OF_NEURONS = 5,
    parameter int FIFO_DEPTH    = 4,
    localparam int ADDR_W       = aer_addr_w(NO_OF_NEURONS)
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [ADDR_W-1:0]        aer_bus,
    input  logic                     neuron_enable,
    output logic [NO_OF_NEURONS-1:0] spikes_out,
    output logic                     spikes_valid,
    input  logic                     spikes_ready,
    output logic                     frame_drop,
    output logic                     addr_err
`ifdef AER_RX_STATS_EN
    ,
    output logic [15:0]              frame_count,
    output logic [15:0]              drop_count
`endif
);

    localparam logic [ADDR_W-1:0] END_MARKER = ADDR_W'(aer_end_marker(ADDR_W));
    localparam logic [ADDR_W-1:0] N_ADDR     = ADDR_W'(NO_OF_NEURONS);

    rx_state_t                state, state_next;
    logic [NO_OF_NEURONS-1:0] acc, acc_next;
    logic                     is_marker, in_range;
    logic                     commit, push_req, pop;
    logic                     fifo_full, fifo_empty;
    logic [NO_OF_NEURONS-1:0] fifo_dout;

    assign is_marker = (aer_bus == END_MARKER);
    assign in_range  = (aer_bus < N_ADDR);

    // IDLE with enable low is handled exactly like RECV, so no bubble is lost.
    always_comb begin
        state_next = state;
        acc_next   = acc;
        commit     = 1'b0;
        if (!neuron_enable) begin
            if (is_marker) begin
                commit     = 1'b1;
                acc_next   = '0;
                state_next = IDLE;
            end else begin
                if (in_range) acc_next = acc | (NO_OF_NEURONS'(1) << aer_bus);
                state_next = RECV;
            end
        end else begin
            commit     = (state == RECV);
            acc_next   = '0;
            state_next = IDLE;
        end
    end

    assign push_req     = commit && (acc != '0);
    assign spikes_valid = !fifo_empty;
    assign spikes_out   = fifo_empty ? '0 : fifo_dout;
    assign pop          = spikes_valid && spikes_ready;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            acc        <= '0;
            frame_drop <= 1'b0;
            addr_err   <= 1'b0;
        end else begin
            state      <= state_next;
            acc        <= acc_next;
            frame_drop <= push_req && fifo_full && !pop;
            addr_err   <= !neuron_enable && !is_marker && !in_range;
        end
    end

    aer_frame_fifo #(
        .WIDTH (NO_OF_NEURONS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push_req),
        .pop   (pop),
        .din   (acc),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

`ifdef AER_RX_STATS_EN
    logic frame_pushed;
    assign frame_pushed = push_req && (!fifo_full || pop);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            frame_count <= '0;
            drop_count  <= '0;
        end else begin
            if (frame_pushed && frame_count != 16'hFFFF) frame_count <= frame_count + 16'd1;
            if (frame_drop && drop_count != 16'hFFFF)    drop_count  <= drop_count + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_aer_receiver.sv
// Directed scoreboard bench for aer_receiver (N=5, depth 4, marker = all-ones).
module tb_aer_receiver;
    import aer_pkg::*;

    localparam int N      = 5;
    localparam int ADDR_W = aer_addr_w(N);
    localparam logic [ADDR_W-1:0] MARKER = ADDR_W'(aer_end_marker(ADDR_W));

    logic              clk = 1'b0;
    logic              reset;
    logic [ADDR_W-1:0] aer_bus;
    logic              neuron_enable;
    logic [N-1:0]      spikes_out;
    logic              spikes_valid;
    logic              spikes_ready;
    logic              frame_drop;
    logic              addr_err;
`ifdef AER_RX_STATS_EN
    logic [15:0]       frame_count;
    logic [15:0]       drop_count;
    int                exp_frames = 0;
`endif

    logic [N-1:0] exp_q[$];
    int total = 0;
    int passed = 0;
    int drop_seen = 0;
    int err_seen = 0;

    aer_receiver #(.NO_OF_NEURONS(N), .FIFO_DEPTH(4)) dut (
        .clk           (clk),
        .reset         (reset),
        .aer_bus       (aer_bus),
        .neuron_enable (neuron_enable),
        .spikes_out    (spikes_out),
        .spikes_valid  (spikes_valid),
        .spikes_ready  (spikes_ready),
        .frame_drop    (frame_drop),
        .addr_err      (addr_err)
`ifdef AER_RX_STATS_EN
        ,
        .frame_count   (frame_count),
        .drop_count    (drop_count)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    // Drivers: values set here are sampled by the next rising edge.
    task automatic step(input logic en, input logic [ADDR_W-1:0] bus);
        neuron_enable = en;
        aer_bus       = bus;
        @(posedge clk);
        #1;
    endtask

    task automatic expect_frame(input logic [N-1:0] f);
        exp_q.push_back(f);
`ifdef AER_RX_STATS_EN
        exp_frames++;
`endif
    endtask

    task automatic drain(input string name);
        for (int i = 0; i < 40 && (exp_q.size() != 0 || spikes_valid); i++) begin
            @(posedge clk);
            #1;
        end
        check({name, "_queue_empty"}, exp_q.size(), 0);
        check({name, "_valid_low"}, spikes_valid, 0);
    endtask

    // Monitor: every accepted frame must match the head of the expected queue.
    always @(negedge clk) begin
        if (!reset) begin
            if (frame_drop) drop_seen++;
            if (addr_err)   err_seen++;
            if (spikes_valid && spikes_ready) begin
                if (exp_q.size() == 0) begin
                    total++;
                    $display("FAIL unexpected_frame: got 0x%0h, expected no frame at %0t", spikes_out, $time);
                end else begin
                    check("frame", spikes_out, exp_q.pop_front());
                end
            end
        end
    end

    initial begin
        reset = 1'b1;
        neuron_enable = 1'b1;
        aer_bus = '0;
        spikes_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_valid", spikes_valid, 0);
        check("reset_spikes", spikes_out, 0);
        check("reset_drop", frame_drop, 0);
        check("reset_err", addr_err, 0);
        reset = 1'b0;
        step(1, 0);

        // Basic burst 0,2,4 + marker, consumer always ready.
        spikes_ready = 1'b1;
        step(0, 0); step(0, 2); step(0, 4);
        expect_frame(5'b10101);
        step(0, MARKER);
        step(1, 0); step(1, 0);
        drain("t1");

        // Back-to-back bursts held by the consumer.
        spikes_ready = 1'b0;
        step(0, 1); step(0, 3);
        expect_frame(5'b01010);
        step(0, MARKER);
        step(0, 0);
        expect_frame(5'b00001);
        step(0, MARKER);
        step(1, 0);
        check("hold_valid", spikes_valid, 1);
        check("hold_head_a", spikes_out, 5'b01010);
        step(1, 0);
        check("hold_head_b", spikes_out, 5'b01010);
        spikes_ready = 1'b1;
        drain("t2");

        // Five frames into a depth-4 FIFO: the fifth is dropped.
        spikes_ready = 1'b0;
        drop_seen = 0;
        for (int i = 0; i < 5; i++) begin
            if (i < 4) expect_frame(N'(1) << i);
            step(0, ADDR_W'(i));
            step(0, MARKER);
        end
        step(1, 0); step(1, 0);
        check("drop_pulses", drop_seen, 1);
`ifdef AER_RX_STATS_EN
        check("frame_count", frame_count, exp_frames);
        check("drop_count", drop_count, 1);
`endif
        spikes_ready = 1'b1;
        drain("t3");

        // Out-of-range address is ignored and flagged.
        err_seen = 0;
        step(0, 5); step(0, 1);
        expect_frame(5'b00010);
        step(0, MARKER);
        step(1, 0); step(1, 0);
        check("addr_err_pulses", err_seen, 1);
        drain("t4");

        // Marker-only burst pushes nothing; an enable-terminated burst commits.
        step(0, MARKER);
        for (int i = 0; i < 3; i++) begin
            step(1, 0);
            check("empty_burst_valid", spikes_valid, 0);
        end
        step(0, 3);
        expect_frame(5'b01000);
        step(1, 0);
        drain("t5");

        // Reset mid-burst wipes the partial frame and the queued frame.
        spikes_ready = 1'b0;
        step(0, 1); step(0, MARKER);
        step(0, 2);
        reset = 1'b1;
        #2;
        exp_q.delete();
`ifdef AER_RX_STATS_EN
        exp_frames = 0;
`endif
        check("midreset_valid", spikes_valid, 0);
        check("midreset_spikes", spikes_out, 0);
        step(1, 0);
        reset = 1'b0;
        spikes_ready = 1'b1;
        step(0, 4);
        expect_frame(5'b10000);
        step(0, MARKER);
        step(1, 0);
        drain("t6");
`ifdef AER_RX_STATS_EN
        check("frame_count_after_reset", frame_count, exp_frames);
        check("drop_count_after_reset", drop_count, 0);
`endif

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
